matrix_stream_make: RTL

Parametrised matrix builder for the lineq_solve datapath. It accepts an m×n matrix as a row-major stream of DATA_W-bit elements over a valid/ready handshake. It packs the elements into a flat MAX_M×MAX_N register image, optionally transposed, and holds that image for downstream solver blocks. It replaces the fixed 128×128×32 bulk-load matrix maker with generic width and depth, zero-fill, dimension checking and a transpose mode.

---
 rtl/matrix_stream_make.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_stream_make.sv
// matrix_stream_make
//   Builds an m x n matrix from a row-major element stream and holds it as a
//   flat MAX_M x MAX_N register image for downstream solver blocks. The image
//   can optionally be stored transposed. Positions outside the active region
//   read as zero.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   make       : start request, sampled only in IDLE
//   m_dim      : source rows
//   n_dim      : source columns
//   transpose  : 1 = store the transpose of the source
//   in_valid   : element valid
//   in_data    : element, source row-major order
//   in_ready   : high in LOAD
//   busy       : high in LOAD
//   done       : one-cycle completion pulse
//   err        : one-cycle pulse on a rejected make
//   out_m      : rows of the stored image
//   out_n      : columns of the stored image
//   matrix_out : packed image, element (r,c) at flat index r*MAX_N+c
//   state_dbg  : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: an element transfers on a rising edge where in_valid && in_ready
// are both high. in_ready depends only on the FSM state, never on in_valid;
// in_valid is ignored while in_ready is low.
module matrix_stream_make #(
  parameter int DATA_W = 32,
  parameter int MAX_M  = 4,
  parameter int MAX_N  = 4,
  parameter int DIM_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          make,
  input  logic [DIM_W-1:0]              m_dim,
  input  logic [DIM_W-1:0]              n_dim,
  input  logic                          transpose,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [DIM_W-1:0]              out_m,
  output logic [DIM_W-1:0]              out_n,
  output logic [MAX_M*MAX_N*DATA_W-1:0] matrix_out,
  output logic [1:0]                    state_dbg
);

  localparam int CELLS = MAX_M * MAX_N;
  // One spare bit so the MAX_N multiplier constant always fits.
  localparam int IDX_W = $clog2(CELLS) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CELLS*DATA_W-1:0] matrix_q;
  logic [DIM_W-1:0]        m_q, n_q, row_q, col_q;
  logic                    tr_q;
  logic [DIM_W-1:0]        out_m_q, out_n_q;
  logic                    err_q;

  logic                    dims_ok;
  logic                    accept;
  logic                    reject;
  logic                    hs;
  logic                    col_last;
  logic                    last_elem;
  logic [IDX_W-1:0]        idx;

  // The dims are checked against the shape of the image as it will be stored,
  // so transpose swaps which limit applies to which dimension.
  always_comb begin
    dims_ok = (m_dim != '0) && (n_dim != '0);
    if (transpose) begin
      dims_ok = dims_ok && (n_dim <= DIM_W'(MAX_M)) && (m_dim <= DIM_W'(MAX_N));
    end else begin
      dims_ok = dims_ok && (m_dim <= DIM_W'(MAX_M)) && (n_dim <= DIM_W'(MAX_N));
    end
  end

  assign hs        = in_valid && (state_q == S_LOAD);
  assign col_last  = (col_q == n_q - DIM_W'(1));
  assign last_elem = col_last && (row_q == m_q - DIM_W'(1));

  // Source (row,col) lands at (row,col), or at (col,row) when transposed.
  always_comb begin
    if (tr_q) begin
      idx = IDX_W'(col_q) * IDX_W'(MAX_N) + IDX_W'(row_q);
    end else begin
      idx = IDX_W'(row_q) * IDX_W'(MAX_N) + IDX_W'(col_q);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (make) begin
          if (dims_ok) begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (hs && last_elem) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix_q <= '0;
      m_q      <= '0;
      n_q      <= '0;
      tr_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      out_m_q  <= '0;
      out_n_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        // Clearing here is what zero-fills everything outside the new region.
        matrix_q <= '0;
        m_q      <= m_dim;
        n_q      <= n_dim;
        tr_q     <= transpose;
        row_q    <= '0;
        col_q    <= '0;
        out_m_q  <= transpose ? n_dim : m_dim;
        out_n_q  <= transpose ? m_dim : n_dim;
      end else if (hs) begin
        for (int c = 0; c < CELLS; c++) begin
          if (idx == IDX_W'(c)) matrix_q[c*DATA_W +: DATA_W] <= in_data;
        end
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
    end
  end

  // Status outputs are decodes of the state register only.
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign out_m      = out_m_q;
  assign out_n      = out_n_q;
  assign matrix_out = matrix_q;
  assign state_dbg  = state_q;

endmodule
